// File: rtl/dem_pkg.sv
// dem_pkg: shared types and helpers for the DEM switching-tree nodes.
//   dem_mode_t  : switching-sequence mode selector (MODE_DETERM/RANDOM/SHAPE1/SHAPE2)
//   DEF_ACC_W   : default signed width of the loop-filter accumulators
//   sat_sym()   : symmetric saturation to +/-(2^(w-1)-1)
package dem_pkg;

  typedef enum logic [1:0] {
    MODE_DETERM = 2'd0,
    MODE_RANDOM = 2'd1,
    MODE_SHAPE1 = 2'd2,
    MODE_SHAPE2 = 2'd3
  } dem_mode_t;

  localparam int DEF_ACC_W = 8;

  // Symmetric clamp keeps the loop filter free of the asymmetric most-negative code.
  function automatic logic signed [31:0] sat_sym(input logic signed [31:0] v, input int w);
    logic signed [31:0] lim;
    lim = (32'sd1 <<< (w - 1)) - 32'sd1;
    if (v > lim) return lim;
    if (v < -lim) return -lim;
    return v;
  endfunction

endpackage

// File: rtl/dem_parity_quantizer.sv
// dem_parity_quantizer: combinational parity-correct quantizer for a DEM node.
//   w_i     : signed loop-filter demand
//   p_i     : required parity of the switching value (input code LSB)
//   pn_i    : pseudorandom tie-break when w_i has the wrong parity
//   limit_i : unsigned magnitude bound (same parity as p_i)
//   s_o     : signed switching value, parity p_i, |s_o| <= limit_i
module dem_parity_quantizer #(
  parameter int W_W = 9,
  parameter int S_W = 4
) (
  input  logic signed [W_W-1:0] w_i,
  input  logic                  p_i,
  input  logic                  pn_i,
  input  logic        [S_W-1:0] limit_i,
  output logic signed [S_W-1:0] s_o
);

  localparam int CW = ((W_W > S_W) ? W_W : S_W) + 2;

  logic signed [CW-1:0] wx, lim, q, qc;

  assign wx  = CW'(w_i);
  assign lim = CW'(limit_i);

  always_comb begin
    q = wx;
    if (w_i[0] != p_i) q = pn_i ? (wx + CW'(1)) : (wx - CW'(1));
    // limit shares the parity of q, so clamping never breaks parity
    if (q > lim)       qc = lim;
    else if (q < -lim) qc = -lim;
    else               qc = q;
  end

  assign s_o = S_W'(qc);

endmodule

// File: rtl/dem_switch_node.sv
// dem_switch_node: one node of a tree/segmented DEM DAC.
//   Splits x into x1=(x+s)/2 and x2=(x-s)/2 with a mode-selected switching value s.
//   clk_i, reset_i (sync, active-high), valid_i, x_in_i[LEVEL:0], mode_i, pn_seq_i, clear_i
//   valid_o, x_out1_o, x_out2_o, s_out_o (signed), range_err_o (pulse), sat_o (sticky)
//   All outputs registered, one cycle latency.
module dem_switch_node
  import dem_pkg::*;
#(
  parameter int LEVEL = 3,
  parameter int ACC_W = DEF_ACC_W
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    valid_i,
  input  logic        [LEVEL:0]   x_in_i,
  input  logic        [1:0]       mode_i,
  input  logic                    pn_seq_i,
  input  logic                    clear_i,
  output logic                    valid_o,
  output logic        [LEVEL-1:0] x_out1_o,
  output logic        [LEVEL-1:0] x_out2_o,
  output logic signed [LEVEL:0]   s_out_o,
  output logic                    range_err_o,
  output logic                    sat_o
);

  localparam int XW = LEVEL + 1;
  localparam int WW = ACC_W + 1;
  localparam logic [LEVEL:0] FULL = {1'b1, {LEVEL{1'b0}}};

  dem_mode_t                mode_q, mode_in;
  logic signed [ACC_W-1:0]  acc1_q, acc2_q, acc1_e, acc2_e, acc1_d, acc2_d, acc1_n, acc2_n;
  logic                     valid_q, rerr_q, sat_q, sat_set, ov1, ov2, mode_chg, p;
  logic        [LEVEL-1:0]  x1_q, x2_q, x1_d, x2_d;
  logic signed [LEVEL:0]    s_q, s_d, s_shape;
  logic        [LEVEL:0]    xc, limit;
  logic signed [WW-1:0]     w, acc1_sum, acc2_sum;
  logic signed [31:0]       acc1_s, acc2_s;
  logic signed [XW:0]       sum, dif;

  assign mode_in  = dem_mode_t'(mode_i);
  assign mode_chg = (mode_in != mode_q);
  // A mode switch restarts the loop filter; s is computed from the zeroed state.
  assign acc1_e   = mode_chg ? '0 : acc1_q;
  assign acc2_e   = mode_chg ? '0 : acc2_q;

  assign xc    = (x_in_i > FULL) ? FULL : x_in_i;
  assign limit = (xc <= FULL - xc) ? xc : (FULL - xc);
  assign p     = xc[0];

  always_comb begin
    if (mode_in == MODE_SHAPE2) w = -(WW'(acc1_e) + WW'(acc2_e));
    else                        w = -WW'(acc1_e);
  end

  dem_parity_quantizer #(.W_W(WW), .S_W(XW)) u_quant (
    .w_i     (w),
    .p_i     (p),
    .pn_i    (pn_seq_i),
    .limit_i (limit),
    .s_o     (s_shape)
  );

  always_comb begin
    s_d = s_shape;
    case (mode_in)
      MODE_DETERM: s_d = {{LEVEL{1'b0}}, p};
      MODE_RANDOM: begin
        if (!p)            s_d = '0;
        else if (pn_seq_i) s_d = {{LEVEL{1'b0}}, 1'b1};
        else               s_d = {XW{1'b1}};
      end
      default:     s_d = s_shape;
    endcase
  end

  // Both sums are even and lie in 0..2^LEVEL, so the halving is exact.
  assign sum  = $signed({1'b0, xc}) + (XW+1)'(s_d);
  assign dif  = $signed({1'b0, xc}) - (XW+1)'(s_d);
  assign x1_d = LEVEL'(sum >>> 1);
  assign x2_d = LEVEL'(dif >>> 1);

  always_comb begin
    acc1_sum = WW'(acc1_e) + WW'(s_d);
    acc1_s   = sat_sym(32'(acc1_sum), ACC_W);
    acc1_n   = ACC_W'(acc1_s);
    ov1      = (acc1_s != 32'(acc1_sum));
    acc2_sum = WW'(acc2_e) + WW'(acc1_n);
    acc2_s   = sat_sym(32'(acc2_sum), ACC_W);
    acc2_n   = ACC_W'(acc2_s);
    ov2      = (acc2_s != 32'(acc2_sum));
    acc1_d   = acc1_e;
    acc2_d   = acc2_e;
    sat_set  = 1'b0;
    case (mode_in)
      MODE_SHAPE1: begin acc1_d = acc1_n; acc2_d = '0;     sat_set = ov1;       end
      MODE_SHAPE2: begin acc1_d = acc1_n; acc2_d = acc2_n; sat_set = ov1 | ov2; end
      default:     ;
    endcase
  end

  // ---- output / state register stage ----
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      valid_q <= 1'b0;
      rerr_q  <= 1'b0;
      sat_q   <= 1'b0;
      mode_q  <= MODE_DETERM;
      acc1_q  <= '0;
      acc2_q  <= '0;
      x1_q    <= '0;
      x2_q    <= '0;
      s_q     <= '0;
    end else begin
      valid_q <= valid_i;
      rerr_q  <= valid_i && (x_in_i > FULL);
      if (valid_i) begin
        mode_q <= mode_in;
        acc1_q <= acc1_d;
        acc2_q <= acc2_d;
        x1_q   <= x1_d;
        x2_q   <= x2_d;
        s_q    <= s_d;
        if (sat_set) sat_q <= 1'b1;
      end
      if (clear_i) begin
        acc1_q <= '0;
        acc2_q <= '0;
        sat_q  <= 1'b0;
      end
    end
  end

  assign valid_o     = valid_q;
  assign x_out1_o    = x1_q;
  assign x_out2_o    = x2_q;
  assign s_out_o     = s_q;
  assign range_err_o = rerr_q;
  assign sat_o       = sat_q;

endmodule

// File: tb/tb_dem_switch_node.sv
// tb_dem_switch_node: directed-vector bench for dem_switch_node.
//   u_dut : LEVEL=3, ACC_W=8 (main function checks)
//   u_sat : LEVEL=3, ACC_W=4 (shares stimulus; used for saturation checks)
module tb_dem_switch_node;

  localparam int DET = 0, RND = 1, SH1 = 2, SH2 = 3;

  logic clk = 1'b0;
  logic reset = 1'b1, valid = 1'b0, pn = 1'b0, clr = 1'b0;
  logic [3:0] x_in = '0;
  logic [1:0] mode = '0;

  logic              d_vld, d_rerr, d_sat;
  logic        [2:0] d_x1, d_x2;
  logic signed [3:0] d_s;
  logic              t_vld, t_rerr, t_sat;
  logic        [2:0] t_x1, t_x2;
  logic signed [3:0] t_s;

  int n_vec = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  dem_switch_node #(.LEVEL(3), .ACC_W(8)) u_dut (
    .clk_i(clk), .reset_i(reset), .valid_i(valid), .x_in_i(x_in), .mode_i(mode),
    .pn_seq_i(pn), .clear_i(clr), .valid_o(d_vld), .x_out1_o(d_x1), .x_out2_o(d_x2),
    .s_out_o(d_s), .range_err_o(d_rerr), .sat_o(d_sat)
  );

  dem_switch_node #(.LEVEL(3), .ACC_W(4)) u_sat (
    .clk_i(clk), .reset_i(reset), .valid_i(valid), .x_in_i(x_in), .mode_i(mode),
    .pn_seq_i(pn), .clear_i(clr), .valid_o(t_vld), .x_out1_o(t_x1), .x_out2_o(t_x2),
    .s_out_o(t_s), .range_err_o(t_rerr), .sat_o(t_sat)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Apply one input vector for one clock, then sample 1 ns after the edge.
  task automatic step(input bit v, input int x, input int md, input bit pnb, input bit c);
    valid = v;
    x_in  = 4'(x);
    mode  = 2'(md);
    pn    = pnb;
    clr   = c;
    @(posedge clk);
    #1;
  endtask

  task automatic exp_main(input string tag, input int s, input int x1, input int x2);
    chk({tag, ".vld"}, int'(d_vld), 1);
    chk({tag, ".s"},   int'(d_s),   s);
    chk({tag, ".x1"},  int'(d_x1),  x1);
    chk({tag, ".x2"},  int'(d_x2),  x2);
  endtask

  task automatic exp_sat(input string tag, input int s, input int x1, input int x2);
    chk({tag, ".s"},  int'(t_s),  s);
    chk({tag, ".x1"}, int'(t_x1), x1);
    chk({tag, ".x2"}, int'(t_x2), x2);
  endtask

  initial begin
    // power-up reset
    step(0, 0, DET, 0, 0);
    step(0, 0, DET, 0, 0);
    reset = 1'b0;

    // some activity before the mid-stream reset
    step(1, 5, DET, 0, 0);
    exp_main("det_x5", 1, 3, 2);
    step(1, 9, RND, 1, 0);
    chk("pre_rst_rerr", int'(d_rerr), 1);

    // reset wins over valid
    reset = 1'b1;
    step(1, 5, SH1, 1, 1);
    step(1, 5, SH1, 1, 1);
    chk("rst.vld",  int'(d_vld),  0);
    chk("rst.s",    int'(d_s),    0);
    chk("rst.x1",   int'(d_x1),   0);
    chk("rst.x2",   int'(d_x2),   0);
    chk("rst.rerr", int'(d_rerr), 0);
    chk("rst.sat",  int'(d_sat),  0);
    reset = 1'b0;

    // SHAPE1, x=3 held: s alternates +1/-1
    step(1, 3, SH1, 1, 0); exp_main("sh1_a", 1, 2, 1);
    step(1, 3, SH1, 1, 0); exp_main("sh1_b", -1, 1, 2);
    step(1, 3, SH1, 1, 0); exp_main("sh1_c", 1, 2, 1);
    step(1, 3, SH1, 1, 0); exp_main("sh1_d", -1, 1, 2);
    step(1, 4, SH1, 1, 0); exp_main("sh1_x4", 0, 2, 2);
    step(1, 8, SH1, 1, 0); exp_main("sh1_x8", 0, 4, 4);
    step(1, 0, SH1, 1, 0); exp_main("sh1_x0", 0, 0, 0);

    // RANDOM
    step(1, 5, RND, 1, 0); exp_main("rnd_pn1", 1, 3, 2);
    step(1, 5, RND, 0, 0); exp_main("rnd_pn0", -1, 2, 3);
    step(1, 6, RND, 1, 0); exp_main("rnd_x6", 0, 3, 3);

    // out-of-range input clamps to 8 and pulses range_err for one cycle
    step(1, 9, RND, 1, 0); exp_main("rng_x9", 0, 4, 4);
    chk("rng_err1", int'(d_rerr), 1);
    step(1, 5, RND, 1, 0); exp_main("rng_next", 1, 3, 2);
    chk("rng_err0", int'(d_rerr), 0);

    // valid gap: outputs hold, valid_o low
    step(0, 2, RND, 0, 0);
    chk("gap.vld", int'(d_vld), 0);
    chk("gap.s",   int'(d_s),   1);
    chk("gap.x1",  int'(d_x1),  3);
    chk("gap.x2",  int'(d_x2),  2);
    chk("gap.rerr", int'(d_rerr), 0);

    // DETERM
    step(1, 5, DET, 1, 0); exp_main("det_b", 1, 3, 2);
    step(1, 4, DET, 0, 0); exp_main("det_x4", 0, 2, 2);

    // SHAPE2 walk to acc1=2, acc2=3
    step(1, 1, SH2, 0, 0); exp_main("sh2_1", -1, 0, 1);   // (-1,-1)
    step(1, 0, SH2, 0, 0); exp_main("sh2_2", 0, 0, 0);    // (-1,-2)
    step(1, 0, SH2, 0, 0); exp_main("sh2_3", 0, 0, 0);    // (-1,-3)
    step(1, 6, SH2, 0, 0); exp_main("sh2_4", 2, 4, 2);    // (1,-2)
    step(1, 4, SH2, 1, 0); exp_main("sh2_5", 2, 3, 1);    // (3,1)
    // gap with a different mode: must neither store mode nor touch acc
    step(0, 0, SH1, 0, 0);
    chk("sh2_gap.vld", int'(d_vld), 0);
    chk("sh2_gap.s",   int'(d_s),   2);
    step(1, 1, SH2, 1, 0); exp_main("sh2_6", -1, 0, 1);   // (2,3)
    step(1, 6, SH2, 0, 0); exp_main("sh2_7", -2, 2, 4);   // w=-5 -> (0,3)

    // clear, then acc=0 gives s=+1 (acc (0,3) would give s=-3)
    step(0, 0, SH2, 0, 1);
    chk("clr.vld", int'(d_vld), 0);
    step(1, 3, SH2, 1, 0); exp_main("clr_after", 1, 2, 1); // (1,1)

    // saturation: x=0 keeps acc1=1 so acc2 climbs by one per cycle
    for (int k = 1; k <= 6; k++) step(1, 0, SH2, 0, 0);
    chk("sat_pre.t", int'(t_sat), 0);
    step(1, 0, SH2, 0, 0);
    chk("sat_hit.t", int'(t_sat), 1);
    chk("sat_hit.d", int'(d_sat), 0);
    // acc2 clamped to +7 (a wrap to -8 would give s=+4)
    step(1, 4, SH2, 0, 0); exp_sat("sat_val", -4, 0, 4);
    chk("sat_stick", int'(t_sat), 1);

    // mode change zeroes accumulators (acc1=-3 would give s=+3); sat stays
    step(1, 3, SH1, 1, 0); exp_sat("mchg", 1, 2, 1);
    chk("mchg.sat", int'(t_sat), 1);

    // clear drops the sticky flag
    step(0, 0, SH1, 0, 1);
    chk("clr_sat.t", int'(t_sat), 0);
    chk("clr_sat.vld", int'(t_vld), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
